// File: rtl/system_memory_stream_reader.sv
// Avalon-MM burst-less read master streaming LENGTH words from BASE_ADDR into an FWFT FIFO; start->read 1 clk, read->st_valid 2 clk.
// Outstanding reads are credit-limited by free FIFO space, so st_ready back-pressure stalls the bus instead of dropping data.
module system_memory_stream_reader #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 15,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_length,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_avm_address,
    output logic              o_avm_read,
    input  logic              i_avm_waitrequest,
    input  logic [DATA_W-1:0] i_avm_readdata,
    input  logic              i_avm_readdatavalid,
    output logic [DATA_W-1:0] o_st_data,
    output logic              o_st_valid,
    input  logic              i_st_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]   CREDIT_MAX = FIFO_DEPTH[CNT_W:0];
    localparam logic [LEN_W-1:0] LEN_ONE    = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                w_start_ok;
    logic [ADDR_W-1:0]   r_addr;
    logic [LEN_W-1:0]    r_issue_left;
    logic [LEN_W-1:0]    r_recv_left;
    logic [CNT_W-1:0]    r_outstanding;
    logic [CNT_W-1:0]    r_fifo_count;
    logic [CNT_W-1:0]    w_count_nxt;
    logic [LEN_W-1:0]    w_recv_nxt;
    logic [CNT_W:0]      w_credit;
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic                w_accept;
    logic                w_rdv;
    logic                w_pop;

    // Credits count both in-flight reads and occupied FIFO slots, so every response has a slot waiting.
    assign w_credit   = {1'b0, r_outstanding} + {1'b0, r_fifo_count};
    assign o_avm_read = (r_state == S_RUN) && (r_issue_left != '0) && (w_credit < CREDIT_MAX);
    assign o_avm_address = r_addr;
    assign w_accept   = o_avm_read & ~i_avm_waitrequest;
    assign w_rdv      = i_avm_readdatavalid && (r_outstanding != '0);
    assign o_st_valid = (r_fifo_count != '0);
    assign w_pop      = o_st_valid & i_st_ready;
    assign o_st_data  = o_st_valid ? r_mem[r_rptr] : '0;
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign w_recv_nxt = r_recv_left - {{(LEN_W-1){1'b0}}, w_rdv};

    always_comb begin
        w_count_nxt = r_fifo_count;
        if (w_rdv && !w_pop) begin
            w_count_nxt = r_fifo_count + 1'b1;
        end else if (!w_rdv && w_pop) begin
            w_count_nxt = r_fifo_count - 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_start_ok  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_length != '0) begin
                        w_state_nxt = S_RUN;
                        w_start_ok  = 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (w_accept && (r_issue_left == LEN_ONE)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Look at post-edge occupancy so done and the busy fall coincide with the last pop.
                if ((w_recv_nxt == '0) && (w_count_nxt == '0)) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= S_IDLE;
            r_done        <= 1'b0;
            r_addr        <= '0;
            r_issue_left  <= '0;
            r_recv_left   <= '0;
            r_outstanding <= '0;
            r_fifo_count  <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_done       <= w_done_nxt;
            r_fifo_count <= w_count_nxt;
            if (w_start_ok) begin
                r_addr       <= i_base_addr;
                r_issue_left <= i_length;
                r_recv_left  <= i_length;
            end else begin
                if (w_accept) begin
                    r_addr       <= r_addr + 1'b1;
                    r_issue_left <= r_issue_left - 1'b1;
                end
                r_recv_left <= w_recv_nxt;
            end
            case ({w_accept, w_rdv})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_rdv) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: st_data is masked while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (w_rdv) begin
            r_mem[r_wptr] <= i_avm_readdata;
        end
    end
endmodule

// File: tb/tb_system_memory_stream_reader.sv
`timescale 1ns/1ps
module tb_system_memory_stream_reader;
    localparam int AW = 14;
    localparam int MEM_N = 1 << AW;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] base_addr = '0;
    logic [14:0] length = '0;
    logic        busy, done, avm_read, st_valid;
    logic [13:0] avm_address;
    logic [31:0] st_data;
    logic        waitreq = 1'b0;
    logic        rdv = 1'b0;
    logic [31:0] readdata = '0;
    logic        st_ready = 1'b0;

    always #5 clk = ~clk;

    system_memory_stream_reader #(.ADDR_W(14), .DATA_W(32), .LEN_W(15), .FIFO_DEPTH(8)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_base_addr(base_addr),
        .i_length(length), .o_busy(busy), .o_done(done), .o_avm_address(avm_address),
        .o_avm_read(avm_read), .i_avm_waitrequest(waitreq), .i_avm_readdata(readdata),
        .i_avm_readdatavalid(rdv), .o_st_data(st_data), .o_st_valid(st_valid), .i_st_ready(st_ready)
    );

    logic [31:0] mem [MEM_N];
    int n_cmp = 0;
    int n_bad = 0;

    bit stall_en = 0;
    int max_delay = 1;
    int ready_mode = 1;
    bit inj_rdv = 0;

    logic [13:0] acc_log[$];
    logic [31:0] rx_log[$];
    logic [13:0] pend_addr[$];
    int          pend_due[$];
    int done_cnt = 0, stall_viol = 0, hold_viol = 0, valid_viol = 0, max_credit = 0;
    int cyc = 0, last_due = 0, fifo_occ = 0;

    // Slave with in-order variable-latency responses plus a consumer; records what it observes.
    initial begin : slave_consumer
        bit prev_stall, prev_hold;
        logic [13:0] prev_addr;
        logic [31:0] prev_data;
        int d, due, credit;
        prev_stall = 0; prev_hold = 0; prev_addr = '0; prev_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                pend_addr.delete(); pend_due.delete();
                fifo_occ = 0; prev_stall = 0; prev_hold = 0;
                waitreq = 1'b0; rdv = 1'b0;
            end else begin
                if (prev_stall && !(avm_read && avm_address == prev_addr)) stall_viol++;
                if (prev_hold && (!st_valid || st_data !== prev_data)) hold_viol++;
                if (st_valid !== (fifo_occ != 0)) valid_viol++;
                credit = pend_addr.size() + fifo_occ;
                if (credit > max_credit) max_credit = credit;
                if (done) done_cnt++;
                rdv = 1'b0;
                readdata = $urandom;
                if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
                    rdv = 1'b1;
                    readdata = mem[pend_addr.pop_front()];
                    void'(pend_due.pop_front());
                    fifo_occ++;
                end else if (inj_rdv) begin
                    rdv = 1'b1;
                end
                waitreq = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
                if (avm_read && !waitreq) begin
                    acc_log.push_back(avm_address);
                    d = $urandom_range(1, max_delay);
                    due = cyc + d;
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    pend_addr.push_back(avm_address);
                    pend_due.push_back(due);
                end
                prev_stall = avm_read && waitreq;
                prev_addr = avm_address;
                case (ready_mode)
                    0: st_ready = 1'b0;
                    1: st_ready = 1'b1;
                    default: st_ready = ($urandom_range(0, 1) == 1);
                endcase
                if (st_valid && st_ready) begin
                    rx_log.push_back(st_data);
                    fifo_occ--;
                end
                prev_hold = st_valid && !st_ready;
                prev_data = st_data;
            end
        end
    end

    task automatic clear_logs();
        acc_log.delete(); rx_log.delete();
        done_cnt = 0; stall_viol = 0; hold_viol = 0; valid_viol = 0; max_credit = 0;
    endtask

    task automatic kick(input logic [13:0] b, input logic [14:0] n);
        @(negedge clk);
        base_addr = b; length = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        for (int c = 0; c < limit && done_cnt == 0; c++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    // Reference: the n words starting at b, wrapping modulo the address space.
    function automatic int addr_errs(logic [13:0] b, int n);
        int e;
        logic [13:0] a;
        e = (acc_log.size() != n) ? 1 : 0;
        for (int i = 0; i < n && i < acc_log.size(); i++) begin
            a = b + i[13:0];
            if (acc_log[i] !== a) e++;
        end
        return e;
    endfunction

    function automatic int data_errs(logic [13:0] b, int n);
        int e;
        logic [13:0] a;
        e = (rx_log.size() != n) ? 1 : 0;
        for (int i = 0; i < n && i < rx_log.size(); i++) begin
            a = b + i[13:0];
            if (rx_log[i] !== mem[a]) e++;
        end
        return e;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, avm_read, st_valid} !== 4'b0 || avm_address !== '0 || st_data !== '0) begin
            n_bad++;
            $display("FAIL reset_hold got busy%b done%b rd%b vld%b addr%h data%h want all 0",
                     busy, done, avm_read, st_valid, avm_address, st_data);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, avm_read, st_valid} !== 4'b0 || avm_address !== '0 || st_data !== '0) begin
            n_bad++;
            $display("FAIL reset_idle got busy%b done%b rd%b vld%b addr%h data%h want all 0",
                     busy, done, avm_read, st_valid, avm_address, st_data);
        end
    endtask

    task automatic test_basic();
        bit eb, ed, er, ev;
        clear_logs();
        stall_en = 0; max_delay = 1; ready_mode = 1;
        kick(14'h0010, 15'd4);
        for (int c = 1; c <= 10; c++) begin
            eb = (c >= 1 && c <= 6); ed = (c == 7); er = (c >= 1 && c <= 4); ev = (c >= 3 && c <= 6);
            n_cmp++;
            if ({busy, done, avm_read, st_valid} !== {eb, ed, er, ev}) begin
                n_bad++;
                $display("FAIL basic_timing cycle %0d got busy%b done%b rd%b vld%b want busy%b done%b rd%b vld%b",
                         c, busy, done, avm_read, st_valid, eb, ed, er, ev);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (addr_errs(14'h0010, 4) != 0) begin
            n_bad++; $display("FAIL basic_addr got %0d reads, %0d bad, want 4 reads 0x10..0x13", acc_log.size(), addr_errs(14'h0010, 4));
        end
        n_cmp++;
        if (data_errs(14'h0010, 4) != 0) begin
            n_bad++; $display("FAIL basic_data got %0d words, %0d bad, want 0x10..0x13", rx_log.size(), data_errs(14'h0010, 4));
        end
    endtask

    task automatic test_len_zero();
        clear_logs();
        kick(14'h0100, 15'd0);
        for (int c = 1; c <= 4; c++) begin
            n_cmp++;
            if ({busy, done, avm_read} !== {1'b0, (c == 1), 1'b0}) begin
                n_bad++;
                $display("FAIL len0 cycle %0d got busy%b done%b rd%b want busy0 done%b rd0", c, busy, done, avm_read, (c == 1));
            end
            @(negedge clk);
        end
        n_cmp++;
        if (acc_log.size() != 0 || done_cnt != 1) begin
            n_bad++; $display("FAIL len0_bus got reads %0d dones %0d want 0 and 1", acc_log.size(), done_cnt);
        end
    endtask

    task automatic test_spurious_rdv();
        clear_logs();
        inj_rdv = 1;
        repeat (4) @(negedge clk);
        inj_rdv = 0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (st_valid !== 1'b0 || valid_viol != 0 || busy !== 1'b0 || done_cnt != 0) begin
            n_bad++;
            $display("FAIL spurious_rdv got vld%b viol %0d busy%b dones %0d want 0/0/0/0", st_valid, valid_viol, busy, done_cnt);
        end
    endtask

    task automatic test_wrap();
        clear_logs();
        stall_en = 0; max_delay = 1; ready_mode = 1;
        kick(14'h3FFE, 15'd4);
        wait_done(50);
        n_cmp++;
        if (addr_errs(14'h3FFE, 4) != 0) begin
            n_bad++; $display("FAIL wrap_addr got %0d reads, %0d bad, want 3ffe 3fff 0000 0001", acc_log.size(), addr_errs(14'h3FFE, 4));
        end
        n_cmp++;
        if (data_errs(14'h3FFE, 4) != 0 || done_cnt != 1) begin
            n_bad++; $display("FAIL wrap_data got %0d bad words, %0d dones want 0 and 1", data_errs(14'h3FFE, 4), done_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [13:0] b;
        for (int a = 0; a < MEM_N; a++) mem[a] = $urandom;
        b = 14'($urandom);
        clear_logs();
        stall_en = 0; max_delay = 1; ready_mode = 0;
        kick(b, 15'd20);
        repeat (40) @(negedge clk);
        n_cmp++;
        if (acc_log.size() != 8 || avm_read !== 1'b0 || st_valid !== 1'b1 || rx_log.size() != 0) begin
            n_bad++;
            $display("FAIL bp_stall got reads %0d rd%b vld%b rx %0d want 8 0 1 0", acc_log.size(), avm_read, st_valid, rx_log.size());
        end
        n_cmp++;
        if (max_credit != 8 || hold_viol != 0) begin
            n_bad++; $display("FAIL bp_credit got credit %0d hold_viol %0d want 8 and 0", max_credit, hold_viol);
        end
        ready_mode = 1;
        wait_done(200);
        n_cmp++;
        if (data_errs(b, 20) != 0 || addr_errs(b, 20) != 0 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL bp_release got words %0d bad %0d addr_bad %0d dones %0d want 20 0 0 1",
                     rx_log.size(), data_errs(b, 20), addr_errs(b, 20), done_cnt);
        end
    endtask

    task automatic test_random();
        logic [13:0] b;
        b = 14'($urandom);
        clear_logs();
        stall_en = 1; max_delay = 4; ready_mode = 2;
        kick(b, 15'd100);
        repeat (20) @(negedge clk);
        base_addr = 14'h0000; length = 15'd7; start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(3000);
        n_cmp++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rand_done got dones %0d busy%b want 1 and 0", done_cnt, busy);
        end
        n_cmp++;
        if (stall_viol != 0 || hold_viol != 0 || valid_viol != 0) begin
            n_bad++; $display("FAIL rand_protocol got stall %0d hold %0d valid %0d want all 0", stall_viol, hold_viol, valid_viol);
        end
        n_cmp++;
        if (max_credit > 8) begin
            n_bad++; $display("FAIL rand_credit got %0d want <= 8", max_credit);
        end
        n_cmp++;
        if (addr_errs(b, 100) != 0 || data_errs(b, 100) != 0) begin
            n_bad++;
            $display("FAIL rand_order got reads %0d words %0d addr_bad %0d data_bad %0d want 100 100 0 0",
                     acc_log.size(), rx_log.size(), addr_errs(b, 100), data_errs(b, 100));
        end
        stall_en = 0; max_delay = 1; ready_mode = 1;
    endtask

    task automatic test_mid_reset();
        logic [13:0] b;
        b = 14'($urandom);
        clear_logs();
        stall_en = 0; max_delay = 1; ready_mode = 1;
        kick(b, 15'd50);
        for (int c = 0; c < 200 && rx_log.size() < 10; c++) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, avm_read, st_valid} !== 4'b0 || avm_address !== '0 || st_data !== '0) begin
            n_bad++;
            $display("FAIL midrst_out got busy%b done%b rd%b vld%b addr%h data%h want all 0",
                     busy, done, avm_read, st_valid, avm_address, st_data);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (done_cnt != 0 || busy !== 1'b0 || st_valid !== 1'b0) begin
            n_bad++; $display("FAIL midrst_quiet got dones %0d busy%b vld%b want 0 0 0", done_cnt, busy, st_valid);
        end
        b = 14'($urandom);
        clear_logs();
        kick(b, 15'd5);
        wait_done(100);
        n_cmp++;
        if (addr_errs(b, 5) != 0 || data_errs(b, 5) != 0 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL midrst_restart got words %0d addr_bad %0d data_bad %0d dones %0d want 5 0 0 1",
                     rx_log.size(), addr_errs(b, 5), data_errs(b, 5), done_cnt);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "simulation timeout");
    end

    initial begin : main
        for (int a = 0; a < MEM_N; a++) mem[a] = a;
        test_reset();
        test_basic();
        test_len_zero();
        test_spurious_rdv();
        test_wrap();
        test_backpressure();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
